alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Optional macro ALU_ARB_OPCHK_EN rejects the reserved op 2'b11 and flags it on rsp*_err.
module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [1:0]        req0_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [RES_W-1:0]  rsp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req1_op,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [RES_W-1:0]  rsp1_data,
`ifdef ALU_ARB_OPCHK_EN
  output logic              rsp0_err,
  output logic              rsp1_err,
`endif
  output logic [DATA_W-1:0] alu_in_one,
  output logic [DATA_W-1:0] alu_in_two,
  output logic [1:0]        alu_op,
  input  logic [RES_W-1:0]  alu_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic              grant;
  logic              last_grant;
  logic [DATA_W-1:0] op_a_p0;
  logic [DATA_W-1:0] op_b_p0;
  logic [1:0]        op_c_p0;
  logic [RES_W-1:0]  res_p1;
  logic              win0;
  logic              win1;
  logic              hs0;
  logic              hs1;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [1:0]        sel_op;
  logic              rsp_take;
`ifdef ALU_ARB_OPCHK_EN
  logic              err_p0;
`endif

  // A lone requester always wins; on a tie the one not granted last time wins.
  assign win0 = req0_valid && (!req1_valid || last_grant);
  assign win1 = req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = (state == IDLE) && win0;
  assign req1_ready = (state == IDLE) && win1;
  assign hs0        = req0_valid && req0_ready;
  assign hs1        = req1_valid && req1_ready;

  assign sel_a  = hs1 ? req1_a  : req0_a;
  assign sel_b  = hs1 ? req1_b  : req0_b;
  assign sel_op = hs1 ? req1_op : req0_op;

  assign alu_in_one = op_a_p0;
  assign alu_in_two = op_b_p0;
  assign alu_op     = op_c_p0;

  assign rsp0_valid = (state == RESP) && !grant;
  assign rsp1_valid = (state == RESP) &&  grant;
  assign rsp0_data  = grant ? '0 : res_p1;
  assign rsp1_data  = grant ? res_p1 : '0;
  assign rsp_take   = grant ? rsp1_ready : rsp0_ready;

`ifdef ALU_ARB_OPCHK_EN
  assign rsp0_err = rsp0_valid && err_p0;
  assign rsp1_err = rsp1_valid && err_p0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      op_a_p0    <= '0;
      op_b_p0    <= '0;
      op_c_p0    <= '0;
      res_p1     <= '0;
`ifdef ALU_ARB_OPCHK_EN
      err_p0     <= 1'b0;
`endif
    end else begin
      case (state)
        // p0: capture the winning request into the operand registers
        IDLE: begin
          if (hs0 || hs1) begin
            grant      <= hs1;
            last_grant <= hs1;
            state      <= EXEC;
`ifdef ALU_ARB_OPCHK_EN
            err_p0     <= (sel_op == 2'b11);
            if (sel_op != 2'b11) begin
              op_a_p0 <= sel_a;
              op_b_p0 <= sel_b;
              op_c_p0 <= sel_op;
            end
`else
            op_a_p0    <= sel_a;
            op_b_p0    <= sel_b;
            op_c_p0    <= sel_op;
`endif
          end
        end
        // p1: sample the ALU result
        EXEC: begin
`ifdef ALU_ARB_OPCHK_EN
          res_p1 <= err_p0 ? '0 : alu_out;
`else
          res_p1 <= alu_out;
`endif
          state  <= RESP;
        end
        RESP: begin
          if (rsp_take) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a behavioural ALU closes the loop on alu_* ports.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [7:0]  req0_a, req0_b;
  logic [1:0]  req0_op;
  logic [15:0] rsp0_data;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [7:0]  req1_a, req1_b;
  logic [1:0]  req1_op;
  logic [15:0] rsp1_data;
  logic [7:0]  alu_in_one, alu_in_two;
  logic [1:0]  alu_op;
  logic [15:0] alu_out;
`ifdef ALU_ARB_OPCHK_EN
  logic        rsp0_err, rsp1_err;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    alu_out = 16'hBEEF;
    case (alu_op)
      2'b00: alu_out = {8'h00, alu_in_one} + {8'h00, alu_in_two};
      2'b01: alu_out = {8'h00, alu_in_one} - {8'h00, alu_in_two};
      2'b10: alu_out = alu_in_one * alu_in_two;
      default: alu_out = 16'hBEEF;
    endcase
  end

  alu_arbiter #(.DATA_W(8), .RES_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
`ifdef ALU_ARB_OPCHK_EN
    .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
`endif
    .alu_in_one(alu_in_one), .alu_in_two(alu_in_two), .alu_op(alu_op), .alu_out(alu_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; rsp0_ready = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; rsp1_ready = 0;
    repeat (3) cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_data", rsp0_data, 0);
    chk("rst_rsp1_data", rsp1_data, 0);
    chk("rst_alu_in_one", alu_in_one, 0);
    chk("rst_alu_in_two", alu_in_two, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);

    // single add from requester 0
    req0_valid = 1; req0_a = 8'd10; req0_b = 8'd5; req0_op = 2'b00;
    #1;
    chk("add_req0_ready", req0_ready, 1);
    chk("add_req1_ready", req1_ready, 0);
    cyc();
    req0_valid = 0;
    #1;
    chk("add_alu_in_one", alu_in_one, 10);
    chk("add_alu_in_two", alu_in_two, 5);
    chk("add_alu_op", alu_op, 0);
    chk("add_exec_rsp0_valid", rsp0_valid, 0);
    cyc();
    chk("add_rsp0_valid", rsp0_valid, 1);
    chk("add_rsp0_data", rsp0_data, 16'd15);
    chk("add_rsp1_valid", rsp1_valid, 0);
    rsp0_ready = 1;
    cyc();
    chk("add_done_rsp0_valid", rsp0_valid, 0);
    rsp0_ready = 0;

    // back-to-back requester 1: sub then mul
    rsp1_ready = 1;
    req1_valid = 1; req1_a = 8'd15; req1_b = 8'd7; req1_op = 2'b01;
    #1;
    chk("sub_req1_ready", req1_ready, 1);
    cyc();
    req1_a = 8'd3; req1_b = 8'd4; req1_op = 2'b10;
    #1;
    chk("sub_exec_req1_ready", req1_ready, 0);
    cyc();
    chk("sub_rsp1_valid", rsp1_valid, 1);
    chk("sub_rsp1_data", rsp1_data, 16'd8);
    chk("sub_rsp0_valid", rsp0_valid, 0);
    chk("sub_rsp0_data", rsp0_data, 0);
    chk("sub_resp_req1_ready", req1_ready, 0);
    cyc();
    chk("mul_req1_ready", req1_ready, 1);
    chk("mul_idle_rsp1_valid", rsp1_valid, 0);
    cyc();
    req1_valid = 0;
    cyc();
    chk("mul_rsp1_valid", rsp1_valid, 1);
    chk("mul_rsp1_data", rsp1_data, 16'd12);
    cyc();

    // both requesters valid: grants alternate starting with 0
    req0_valid = 1; req0_a = 8'd10; req0_b = 8'd5; req0_op = 2'b00;
    req1_valid = 1; req1_a = 8'd3;  req1_b = 8'd4; req1_op = 2'b10;
    rsp0_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_req0_ready", req0_ready, (i % 2 == 0));
      chk("rr_req1_ready", req1_ready, (i % 2 == 1));
      cyc();
      cyc();
      chk("rr_rsp0_valid", rsp0_valid, (i % 2 == 0));
      chk("rr_rsp1_valid", rsp1_valid, (i % 2 == 1));
      chk("rr_rsp0_data", rsp0_data, (i % 2 == 0) ? 16'd15 : 16'd0);
      chk("rr_rsp1_data", rsp1_data, (i % 2 == 1) ? 16'd12 : 16'd0);
      cyc();
    end

    // backpressure on requester 0 while requester 1 waits
    rsp0_ready = 0;
    #1;
    chk("bp_req0_ready", req0_ready, 1);
    cyc();
    req0_valid = 0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp0_valid", rsp0_valid, 1);
      chk("bp_rsp0_data", rsp0_data, 16'd15);
      chk("bp_req1_ready", req1_ready, 0);
      cyc();
    end
    chk("bp_last_rsp0_valid", rsp0_valid, 1);
    rsp0_ready = 1;
    cyc();
    #1;
    chk("bp_req1_ready_after", req1_ready, 1);
    chk("bp_rsp0_valid_after", rsp0_valid, 0);
    cyc();

    // reset during EXEC of 3*4 discards it
    rst_n = 0;
    req1_valid = 0;
    cyc();
    chk("mid_rst_rsp1_valid", rsp1_valid, 0);
    chk("mid_rst_alu_in_one", alu_in_one, 0);
    rst_n = 1;
    cyc();
    chk("mid_rst_rsp1_valid_a", rsp1_valid, 0);
    cyc();
    chk("mid_rst_rsp1_valid_b", rsp1_valid, 0);
    req0_valid = 1; req0_a = 8'd5; req0_b = 8'd7; req0_op = 2'b01;
    #1;
    chk("neg_req0_ready", req0_ready, 1);
    cyc();
    req0_valid = 0;
    cyc();
    chk("neg_rsp0_valid", rsp0_valid, 1);
    chk("neg_rsp0_data", rsp0_data, 16'hFFFE);
    cyc();

    // reserved op 2'b11
    req0_valid = 1; req0_a = 8'd9; req0_b = 8'd9; req0_op = 2'b11;
    cyc();
    req0_valid = 0;
    #1;
`ifdef ALU_ARB_OPCHK_EN
    chk("rsv_alu_op_kept", alu_op, 2'b01);
    chk("rsv_alu_in_one_kept", alu_in_one, 5);
    cyc();
    chk("rsv_rsp0_valid", rsp0_valid, 1);
    chk("rsv_rsp0_data", rsp0_data, 0);
    chk("rsv_rsp0_err", rsp0_err, 1);
    chk("rsv_rsp1_err", rsp1_err, 0);
    cyc();
    req0_valid = 1; req0_op = 2'b00;
    cyc();
    req0_valid = 0;
    cyc();
    chk("chk_add_rsp0_data", rsp0_data, 16'd18);
    chk("chk_add_rsp0_err", rsp0_err, 0);
    cyc();
`else
    chk("rsv_alu_op_fwd", alu_op, 2'b11);
    cyc();
    chk("rsv_rsp0_valid", rsp0_valid, 1);
    chk("rsv_rsp0_data", rsp0_data, 16'hBEEF);
    cyc();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
